// File: rtl/nv_nvdla_cvif_rd_eg_rsp_arb.sv
// Read-response egress stage for the CVIF read path.
// Merges NUM_CH DMA response channels into one client response port.
// Every input has a one-entry skid buffer behind a registered ready. A
// round-robin arbiter feeds a single output pipe register that carries
// both the payload and the ID of the channel it came from.
//
// Handshake semantics (all ports): a beat transfers on a rising edge where
// valid and ready are both high. Valid never depends combinationally on
// ready. A producer holds valid/payload stable until the transfer. dma_rdy,
// rsp_valid, rsp_pd and rsp_chid are all driven straight from flops.
module nv_nvdla_cvif_rd_eg_rsp_arb #(
    parameter int PD_WIDTH = 514,
    parameter int NUM_CH   = 5,
    parameter int CHID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rst,
    input  logic [NUM_CH-1:0]          dma_vld,
    output logic [NUM_CH-1:0]          dma_rdy,
    input  logic [NUM_CH*PD_WIDTH-1:0] dma_pd,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [PD_WIDTH-1:0]        rsp_pd,
    output logic [CHID_W-1:0]          rsp_chid
);

    logic [NUM_CH-1:0]   rdy_flop;
    logic [NUM_CH-1:0]   skid_vld;
    logic [PD_WIDTH-1:0] skid_pd [NUM_CH];

    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   gnt;
    logic [NUM_CH-1:0]   take;
    logic [NUM_CH-1:0]   catch_beat;
    logic [PD_WIDTH-1:0] cand_pd [NUM_CH];

    logic [CHID_W-1:0]   last;
    logic [CHID_W-1:0]   gnt_idx;
    logic                arb_found;
    int                  arb_pos;
    logic [CHID_W-1:0]   arb_ch;
    logic [PD_WIDTH-1:0] sel_pd;

    logic                out_rdy_bc;
    logic                any_req;
    logic                load;

    // The output register can accept a new beat when it is empty or being popped.
    assign out_rdy_bc = rsp_ready | ~rsp_valid;
    assign any_req    = |req;
    assign load       = out_rdy_bc & any_req;
    assign dma_rdy    = rdy_flop;

    // While ready is up the channel presents its live input; once ready has
    // dropped the held skid entry is the candidate instead.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign req[i]        = rdy_flop[i] ? dma_vld[i] : skid_vld[i];
        assign cand_pd[i]    = rdy_flop[i] ? dma_pd[i*PD_WIDTH +: PD_WIDTH] : skid_pd[i];
        assign take[i]       = gnt[i] & out_rdy_bc;
        assign catch_beat[i] = dma_vld[i] & rdy_flop[i] & ~take[i];
    end

    // Round-robin grant: first requester after the last winner, wrapping modulo NUM_CH.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        arb_found = 1'b0;
        arb_pos   = 0;
        arb_ch    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            arb_pos = (int'(last) + k) % NUM_CH;
            arb_ch  = CHID_W'(arb_pos);
            if (!arb_found && req[arb_ch]) begin
                gnt[arb_ch] = 1'b1;
                gnt_idx     = arb_ch;
                arb_found   = 1'b1;
            end
        end
    end

    // Payload mux driven by the one-hot grant.
    always_comb begin
        sel_pd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_pd = cand_pd[i];
            end
        end
    end

    // Skid occupancy and registered ready: catch when an accepted beat loses,
    // release ready again the cycle after the held entry is taken.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            rdy_flop <= '1;
            skid_vld <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                skid_vld[i] <= skid_vld[i] ? ~take[i] : catch_beat[i];
                rdy_flop[i] <= skid_vld[i] ? take[i] : ~catch_beat[i];
            end
        end
    end

    // Skid payload storage; contents are meaningless while skid_vld is low.
    always_ff @(posedge nvdla_core_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (catch_beat[i]) begin
                skid_pd[i] <= dma_pd[i*PD_WIDTH +: PD_WIDTH];
            end
        end
    end

    // Output pipe register and arbiter history; both advance only on a load.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            last      <= CHID_W'(NUM_CH - 1);
            rsp_valid <= 1'b0;
            rsp_pd    <= '0;
            rsp_chid  <= '0;
        end else begin
            rsp_valid <= out_rdy_bc ? any_req : 1'b1;
            if (load) begin
                last     <= gnt_idx;
                rsp_pd   <= sel_pd;
                rsp_chid <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cvif_rd_eg_rsp_arb.sv
// Bench for the CVIF read-response egress arbiter (5 channels, 16-bit payload).
// Payload of each beat is {channel[3:0], sequence[11:0]}; accepted beats are
// pushed to a per-channel expected queue and popped when they leave rsp_*.
module tb_nv_nvdla_cvif_rd_eg_rsp_arb;

    localparam int NUM_CH = 5;
    localparam int PD_W   = 16;
    localparam int CHID_W = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        dma_vld;
    logic [NUM_CH-1:0]        dma_rdy;
    logic [NUM_CH*PD_W-1:0]   dma_pd;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [PD_W-1:0]          rsp_pd;
    logic [CHID_W-1:0]        rsp_chid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PD_W-1:0]   exp_q [NUM_CH][$];
    logic [11:0]       seq [NUM_CH];
    logic              prev_stall = 1'b0;
    logic [PD_W-1:0]   prev_pd;
    logic [CHID_W-1:0] prev_chid;
    int                mon_ch;
    logic [PD_W-1:0]   mon_exp;

    nv_nvdla_cvif_rd_eg_rsp_arb #(
        .PD_WIDTH (PD_W),
        .NUM_CH   (NUM_CH)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .dma_vld        (dma_vld),
        .dma_rdy        (dma_rdy),
        .dma_pd         (dma_pd),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_pd         (rsp_pd),
        .rsp_chid       (rsp_chid)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PD_W-1:0] beat(input int ch, input logic [11:0] s);
        return {4'(ch), s};
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NUM_CH; i++) n += exp_q[i].size();
        return n;
    endfunction

    // ---------------- scoreboard / monitor (samples on falling edge) ----------------
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                exp_q[i].delete();
                seq[i] = '0;
            end
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(rsp_valid), 32'd1);
                check("hold_pd", 32'(rsp_pd), 32'(prev_pd));
                check("hold_chid", 32'(rsp_chid), 32'(prev_chid));
            end
            if (rsp_valid && rsp_ready) begin
                mon_ch = int'(rsp_chid);
                if (mon_ch >= NUM_CH) begin
                    check("chid_range", 32'(mon_ch), 32'(NUM_CH - 1));
                end else begin
                    check("pop_avail", 32'(exp_q[mon_ch].size() != 0), 32'd1);
                    if (exp_q[mon_ch].size() != 0) begin
                        mon_exp = exp_q[mon_ch].pop_front();
                        check("pop_pd", 32'(rsp_pd), 32'(mon_exp));
                    end
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (dma_vld[i] && dma_rdy[i]) begin
                    exp_q[i].push_back(dma_pd[i*PD_W +: PD_W]);
                    seq[i] = seq[i] + 12'd1;
                end
            end
            prev_stall = rsp_valid & ~rsp_ready;
            prev_pd    = rsp_pd;
            prev_chid  = rsp_chid;
        end
    end

    // ---------------- driver tasks ----------------
    // One clock; afterwards every channel presents its next unsent beat.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            dma_pd[i*PD_W +: PD_W] = beat(i, seq[i]);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        dma_vld = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int waited = 0;
        dma_vld   = '0;
        rsp_ready = 1'b1;
        while ((pending() != 0 || rsp_valid) && waited < 200) begin
            cycle();
            waited++;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            check(tag, 32'(exp_q[i].size()), 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        dma_vld   = '0;
        dma_pd    = '0;
        rsp_ready = 1'b1;

        // Reset with all channels valid; channel 0 must come out first.
        dma_vld = '1;
        cycle();
        cycle();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdy", 32'(dma_rdy), 32'h1f);
        rst = 1'b0;
        cycle();
        check("rst_first_valid", 32'(rsp_valid), 32'd1);
        check("rst_first_chid", 32'(rsp_chid), 32'd0);
        check("rst_first_pd", 32'(rsp_pd), 32'h0000);
        drain("rst_drain");

        // Single channel 3 streaming eight beats with no bubbles.
        do_reset();
        rsp_ready = 1'b1;
        dma_vld   = 5'b01000;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("stream_rdy3", 32'(dma_rdy[3]), 32'd1);
            check("stream_valid", 32'(rsp_valid), 32'd1);
            check("stream_chid", 32'(rsp_chid), 32'd3);
            check("stream_pd", 32'(rsp_pd), 32'h3000 + 32'(k));
        end
        dma_vld = '0;
        cycle();
        check("stream_end_valid", 32'(rsp_valid), 32'd0);
        drain("stream_drain");

        // Full load: grants rotate 0..4.
        do_reset();
        dma_vld = '1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            check("rr_chid", 32'(rsp_chid), 32'(k % NUM_CH));
        end

        // Back-pressure from full load: output held, all readies fall.
        rsp_ready = 1'b0;
        cycle();
        cycle();
        check("bp_rdy_low", 32'(dma_rdy), 32'h0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("bp_valid", 32'(rsp_valid), 32'd1);
        end
        drain("bp_drain");

        // Random traffic on inputs and output ready.
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            dma_vld   = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            rsp_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drain("rand_drain");

        // Reset while skids and the output register are occupied.
        do_reset();
        dma_vld   = '1;
        rsp_ready = 1'b0;
        cycle();
        cycle();
        cycle();
        rst     = 1'b1;
        dma_vld = '0;
        cycle();
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rdy", 32'(dma_rdy), 32'h1f);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("mid_rst_idle", 32'(rsp_valid), 32'd0);
        end
        dma_vld = 5'b00100;
        cycle();
        check("mid_rst_next_valid", 32'(rsp_valid), 32'd1);
        check("mid_rst_next_chid", 32'(rsp_chid), 32'd2);
        check("mid_rst_next_pd", 32'(rsp_pd), 32'h2000);
        drain("mid_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
